sr_imem_loader: RTL and testbench



---
 rtl/sr_imem_loader.sv | 114 +++++++++++
 tb/tb_sr_imem_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sr_imem_loader.sv
// Boot-time instruction memory loader: packs a byte stream into 32-bit words, holds the CPU
// in reset until the program is loaded, then serves fetches. Define SR_IMEM_CHECKSUM_EN for a running XOR checksum.
module sr_imem_loader #(
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              reload,
    input  logic [31:0]       imAddr,
    output logic [31:0]       imData,
    output logic              cpu_rst,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              err_overflow,
    output logic [31:0]       checksum
);
    localparam int              DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CAP   = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {LOAD, RUN} state_t;

    state_t      state;
    logic [1:0]  byteIdx;
    logic [31:0] wordBuf;
    logic [31:0] packedWord;
    logic [31:0] mem [DEPTH];
    logic        accept;
    logic        full;
    logic        memWr;

    // Unfilled upper bytes of the buffer are always zero, so OR-ing yields the padded word.
    assign packedWord = wordBuf | ({24'h0, in_data} << {byteIdx, 3'b000});
    assign accept     = in_valid && in_ready;
    assign full       = (word_count == CAP);
    assign memWr      = accept && !full && ((byteIdx == 2'd3) || in_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOAD;
            cpu_rst      <= 1'b1;
            in_ready     <= 1'b1;
            load_done    <= 1'b0;
            word_count   <= '0;
            err_overflow <= 1'b0;
            byteIdx      <= '0;
            wordBuf      <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (full) begin
                            err_overflow <= 1'b1;
                        end else if (memWr) begin
                            word_count <= word_count + 1'b1;
                            byteIdx    <= '0;
                            wordBuf    <= '0;
                        end else begin
                            byteIdx <= byteIdx + 1'b1;
                            wordBuf <= packedWord;
                        end
                        if (in_last) begin
                            state     <= RUN;
                            cpu_rst   <= 1'b0;
                            in_ready  <= 1'b0;
                            load_done <= 1'b1;
                            byteIdx   <= '0;
                            wordBuf   <= '0;
                        end
                    end
                end
                RUN: begin
                    if (reload) begin
                        state        <= LOAD;
                        cpu_rst      <= 1'b1;
                        in_ready     <= 1'b1;
                        load_done    <= 1'b0;
                        word_count   <= '0;
                        err_overflow <= 1'b0;
                        byteIdx      <= '0;
                        wordBuf      <= '0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (memWr) mem[word_count[ADDR_W-1:0]] <= packedWord;
    end

    // Stale words beyond word_count (e.g. after reload) must read as NOP.
    always_comb begin
        imData = NOP_WORD;
        if ((imAddr[31:ADDR_W] == '0) && ({1'b0, imAddr[ADDR_W-1:0]} < word_count))
            imData = mem[imAddr[ADDR_W-1:0]];
    end

`ifdef SR_IMEM_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      checksum <= '0;
        else if (state == RUN && reload) checksum <= '0;
        else if (memWr)                  checksum <= checksum ^ packedWord;
    end
`else
    assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_sr_imem_loader.sv
// Directed self-checking bench for sr_imem_loader: fetch-vector table plus hand-written load sequences.
module tb_sr_imem_loader;
    localparam int          ADDR_W = 6;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_last, reload;
    logic [7:0]        in_data;
    logic              in_ready, cpu_rst, load_done, err_overflow;
    logic [31:0]       imAddr, imData, checksum;
    logic [ADDR_W:0]   word_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
        string       name;
    } fetchVec_t;

    fetchVec_t vecs [6];

    sr_imem_loader #(.ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .reload(reload), .imAddr(imAddr), .imData(imData),
        .cpu_rst(cpu_rst), .load_done(load_done), .word_count(word_count),
        .err_overflow(err_overflow), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fetch(input string name, input logic [31:0] a, input logic [31:0] exp);
        imAddr = a;
        #1;
        check(name, imData, exp);
    endtask

    task automatic sendByte(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulseReload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    logic [31:0] expSum;
    logic [31:0] w;

    initial begin
        vecs[0] = '{32'd0,        32'h0000_0013, "fetch0"};
        vecs[1] = '{32'd1,        32'h0010_0093, "fetch1"};
        vecs[2] = '{32'd2,        NOP,           "fetch2_unloaded"};
        vecs[3] = '{32'd63,       NOP,           "fetch63_unloaded"};
        vecs[4] = '{32'h100,      NOP,           "fetch_out_of_range"};
        vecs[5] = '{32'h8000_0001, NOP,          "fetch_high_bits"};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; reload = 1'b0; imAddr = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_cpu_rst",   32'(cpu_rst), 32'd1);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_err",       32'(err_overflow), 32'd0);
        check("rst_checksum",  checksum, 32'd0);
        fetch("rst_fetch0", 32'd0, NOP);

        // Two full words, last on the 4th byte of the second word.
        sendByte(8'h13, 0); sendByte(8'h00, 0); sendByte(8'h00, 0); sendByte(8'h00, 0);
        check("w0_count", 32'(word_count), 32'd1);
        fetch("w0_readable", 32'd0, 32'h0000_0013);
        sendByte(8'h93, 0); sendByte(8'h00, 0); sendByte(8'h10, 0);
        check("pre_last_cpu_rst", 32'(cpu_rst), 32'd1);
        sendByte(8'h00, 1);
        check("t1_cpu_rst",  32'(cpu_rst), 32'd0);
        check("t1_done",     32'(load_done), 32'd1);
        check("t1_in_ready", 32'(in_ready), 32'd0);
        check("t1_count",    32'(word_count), 32'd2);
        for (int i = 0; i < 6; i++) fetch(vecs[i].name, vecs[i].addr, vecs[i].exp);
        sendByte(8'h55, 1);
        check("run_ignores_stream", 32'(word_count), 32'd2);

        pulseReload();
        check("rl_cpu_rst",  32'(cpu_rst), 32'd1);
        check("rl_count",    32'(word_count), 32'd0);
        check("rl_in_ready", 32'(in_ready), 32'd1);
        check("rl_done",     32'(load_done), 32'd0);
        check("rl_err",      32'(err_overflow), 32'd0);
        fetch("rl_fetch0_nop", 32'd0, NOP);

        // Partial last word, with a 5-cycle gap (and an ignored reload) between bytes 2 and 3.
        sendByte(8'hB7, 0); sendByte(8'h12, 0);
        repeat (2) @(posedge clk);
        pulseReload();
        repeat (2) @(posedge clk);
        #1;
        check("gap_no_write", 32'(word_count), 32'd0);
        check("gap_still_load", 32'(cpu_rst), 32'd1);
        sendByte(8'h34, 0); sendByte(8'h56, 0); sendByte(8'hAA, 0); sendByte(8'hBB, 1);
        check("t2_count", 32'(word_count), 32'd2);
        fetch("t2_fetch0", 32'd0, 32'h5634_12B7);
        fetch("t2_fetch1", 32'd1, 32'h0000_BBAA);
        fetch("t2_fetch2", 32'd2, NOP);
`ifdef SR_IMEM_CHECKSUM_EN
        check("t2_checksum", checksum, 32'h5634_A91D);
`else
        check("t2_checksum", checksum, 32'h0);
`endif

        // Overflow: 65 words; word i carries bytes 4i..4i+3.
        pulseReload();
        check("rl2_checksum", checksum, 32'h0);
        expSum = '0;
        for (int i = 0; i < 65; i++) begin
            w = '0;
            for (int b = 0; b < 4; b++) begin
                w[8*b +: 8] = 8'((4*i + b) & 8'hFF);
                sendByte(8'((4*i + b) & 8'hFF), (i == 64) && (b == 3));
                if (i == 64 && b == 0) begin
                    check("ovf_err_set", 32'(err_overflow), 32'd1);
                    check("ovf_in_ready", 32'(in_ready), 32'd1);
                    check("ovf_count_held", 32'(word_count), 32'd64);
                end
            end
            if (i < 64) expSum = expSum ^ w;
        end
        check("ovf_count", 32'(word_count), 32'd64);
        check("ovf_err",   32'(err_overflow), 32'd1);
        check("ovf_done",  32'(load_done), 32'd1);
        fetch("ovf_fetch0",  32'd0,  32'h0302_0100);
        fetch("ovf_fetch63", 32'd63, 32'hFFFE_FDFC);
        fetch("ovf_fetch64", 32'd64, NOP);
`ifdef SR_IMEM_CHECKSUM_EN
        check("ovf_checksum", checksum, expSum);
`else
        check("ovf_checksum", checksum, 32'h0);
`endif
        pulseReload();
        check("rl3_err", 32'(err_overflow), 32'd0);

        // Async reset mid-word discards the partial word.
        sendByte(8'h01, 0); sendByte(8'h02, 0); sendByte(8'h03, 0); sendByte(8'h04, 0);
        sendByte(8'h11, 0); sendByte(8'h22, 0);
        check("pre_rst_count", 32'(word_count), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count",   32'(word_count), 32'd0);
        check("arst_cpu_rst", 32'(cpu_rst), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        sendByte(8'hAA, 0); sendByte(8'hBB, 1);
        check("post_rst_count", 32'(word_count), 32'd1);
        fetch("post_rst_fetch0", 32'd0, 32'h0000_BBAA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
